aes_stream_ctrl: RTL and testbench

Upstream sequencer for the byte-serial AES-128 cipher core. It accepts a 128-bit key and 128-bit plaintext blocks from the host over valid/ready handshakes. It drives the core's cmd/din byte protocol (set key, set plaintext, start), then collects the 16 serial ciphertext bytes into one 128-bit word with a valid/ready output handshake.

---
 rtl/aes_stream_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_aes_stream_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : aes_stream_ctrl
//  Function : Host-side sequencer for a byte-serial AES-128 core. Loads a
//             key once and plaintext blocks over valid/ready, drives the
//             core's cmd/din byte protocol and assembles the 16 serial
//             ciphertext bytes into a 128-bit word with valid/ready output.
//  Revision : 1.0  initial release
// ============================================================================
module aes_stream_ctrl #(
   parameter int OK_TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst_,
   input  logic [127:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] pt_in,
   input  logic         pt_valid,
   output logic         pt_ready,
   output logic [127:0] ct_out,
   output logic         ct_valid,
   input  logic         ct_ready,
   output logic         busy,
   output logic         err,
   output logic [1:0]   core_cmd,
   output logic [7:0]   core_din,
   input  logic         core_ready,
   input  logic         core_ok,
   input  logic [7:0]   core_dout
);

   localparam int TW = $clog2(OK_TIMEOUT + 1);

   localparam logic [1:0] CMD_IDLE  = 2'b00;
   localparam logic [1:0] CMD_START = 2'b01;
   localparam logic [1:0] CMD_KEY   = 2'b10;
   localparam logic [1:0] CMD_PT    = 2'b11;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      KCMD    = 4'd1,
      KSEND   = 4'd2,
      PCMD    = 4'd3,
      PSEND   = 4'd4,
      SETTLE  = 4'd5,
      SCMD    = 4'd6,
      WAIT_OK = 4'd7,
      SKIP    = 4'd8,
      CAPT    = 4'd9,
      OUT     = 4'd10
   } state_t;

   state_t        state_q;
   logic [127:0]  sreg_q;
   logic [127:0]  ct_q;
   logic [3:0]    cnt_q;
   logic [TW-1:0] tmo_q;
   logic          key_loaded_q;
   logic          from_key_q;
   logic          err_q;
   logic          ct_valid_q;
   logic          key_ready_q;
   logic          pt_ready_q;
   logic [1:0]    cmd_q;
   logic [7:0]    din_q;

   logic          can_cmd;

   // A command may only be launched while the core is idle and not emitting
   assign can_cmd = core_ready && !core_ok;

   // Main sequencer: state, datapath registers and all registered outputs
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q      <= IDLE;
         sreg_q       <= '0;
         ct_q         <= '0;
         cnt_q        <= '0;
         tmo_q        <= '0;
         key_loaded_q <= 1'b0;
         from_key_q   <= 1'b0;
         err_q        <= 1'b0;
         ct_valid_q   <= 1'b0;
         key_ready_q  <= 1'b0;
         pt_ready_q   <= 1'b0;
         cmd_q        <= CMD_IDLE;
         din_q        <= 8'h00;
      end else begin
         // Commands and data bytes are single-cycle pulses; ready flags are
         // re-armed only on paths that land in IDLE.
         cmd_q       <= CMD_IDLE;
         din_q       <= 8'h00;
         key_ready_q <= 1'b0;
         pt_ready_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (key_valid && key_ready_q) begin
                  sreg_q     <= key_in;
                  from_key_q <= 1'b1;
                  state_q    <= KCMD;
               end else if (pt_valid && pt_ready_q) begin
                  sreg_q     <= pt_in;
                  from_key_q <= 1'b0;
                  state_q    <= PCMD;
               end else begin
                  key_ready_q <= !key_loaded_q;
                  pt_ready_q  <= key_loaded_q && !ct_valid_q;
               end
            end
            KCMD: begin
               if (can_cmd) begin
                  cmd_q   <= CMD_KEY;
                  cnt_q   <= 4'd0;
                  state_q <= KSEND;
               end
            end
            PCMD: begin
               if (can_cmd) begin
                  cmd_q   <= CMD_PT;
                  cnt_q   <= 4'd0;
                  state_q <= PSEND;
               end
            end
            KSEND, PSEND: begin
               // Byte 0 first; each byte lands on core_din one cycle later
               din_q  <= sreg_q[7:0];
               sreg_q <= {8'h00, sreg_q[127:8]};
               if (cnt_q == 4'd15) begin
                  state_q <= SETTLE;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            SETTLE: begin
               if (core_ready) begin
                  if (from_key_q) begin
                     key_loaded_q <= 1'b1;
                     pt_ready_q   <= 1'b1;
                     state_q      <= IDLE;
                  end else begin
                     state_q <= SCMD;
                  end
               end
            end
            SCMD: begin
               if (can_cmd) begin
                  cmd_q   <= CMD_START;
                  tmo_q   <= '0;
                  state_q <= WAIT_OK;
               end
            end
            WAIT_OK: begin
               // The ok cycle detected here is the unstable one and is dropped
               if (core_ok) begin
                  state_q <= SKIP;
               end else if (tmo_q >= TW'(OK_TIMEOUT - 1)) begin
                  err_q      <= 1'b1;
                  pt_ready_q <= key_loaded_q;
                  state_q    <= IDLE;
               end else if (tmo_q != '1) begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            SKIP: begin
               // First cycle after the discarded ok cycle: byte 0 is stable
               if (!core_ok) begin
                  err_q      <= 1'b1;
                  pt_ready_q <= key_loaded_q;
                  state_q    <= IDLE;
               end else begin
                  ct_q    <= {core_dout, ct_q[127:8]};
                  cnt_q   <= 4'd1;
                  state_q <= CAPT;
               end
            end
            CAPT: begin
               if (!core_ok) begin
                  err_q      <= 1'b1;
                  pt_ready_q <= key_loaded_q;
                  state_q    <= IDLE;
               end else begin
                  ct_q <= {core_dout, ct_q[127:8]};
                  if (cnt_q == 4'd15) begin
                     ct_valid_q <= 1'b1;
                     state_q    <= OUT;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end
            OUT: begin
               if (ct_ready) begin
                  ct_valid_q <= 1'b0;
                  pt_ready_q <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign key_ready = key_ready_q;
   assign pt_ready  = pt_ready_q;
   assign ct_out    = ct_q;
   assign ct_valid  = ct_valid_q;
   assign busy      = (state_q != IDLE);
   assign err       = err_q;
   assign core_cmd  = cmd_q;
   assign core_din  = din_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_stream_ctrl
//  Function : Self-checking bench for aes_stream_ctrl with a behavioural
//             byte-serial core stand-in and a block-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_stream_ctrl;

   localparam logic [127:0] FIPS_KEY = 128'h0F0E0D0C0B0A09080706050403020100;
   localparam logic [127:0] FIPS_PT  = 128'hFFEEDDCCBBAA99887766554433221100;
   localparam logic [127:0] FIPS_CT  = 128'h5AC5B47080B7CDD830047B6AD8E0C469;

   logic         clk;
   logic         rst_;
   logic [127:0] key_in;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] pt_in;
   logic         pt_valid;
   logic         pt_ready;
   logic [127:0] ct_out;
   logic         ct_valid;
   logic         ct_ready;
   logic         busy;
   logic         err;
   logic [1:0]   core_cmd;
   logic [7:0]   core_din;
   logic         core_ready;
   logic         core_ok;
   logic [7:0]   core_dout;

   int total = 0;
   int bad   = 0;

   aes_stream_ctrl #(.OK_TIMEOUT(64)) dut (
      .clk        (clk),
      .rst_       (rst_),
      .key_in     (key_in),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .pt_in      (pt_in),
      .pt_valid   (pt_valid),
      .pt_ready   (pt_ready),
      .ct_out     (ct_out),
      .ct_valid   (ct_valid),
      .ct_ready   (ct_ready),
      .busy       (busy),
      .err        (err),
      .core_cmd   (core_cmd),
      .core_din   (core_din),
      .core_ready (core_ready),
      .core_ok    (core_ok),
      .core_dout  (core_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog got=stuck exp=finish");
      $fatal(1, "watchdog");
   end

   // Stand-in cipher: the real FIPS-197 answer for the known vector,
   // otherwise a simple keyed transform so any byte misrouting shows up.
   function automatic logic [127:0] ref_cipher(input logic [127:0] k, input logic [127:0] p);
      if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
      return p ^ {k[63:0], k[127:64]} ^ 128'h3C3C_A5A5_0F0F_5A5A_C3C3_1234_8765_F00D;
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- core model knobs (written only by the main initial) ---
   int ok_lat    = 5;
   bit ok_never  = 1'b0;
   int ok_cycles = 17;

   // ---------------- behavioural core model --------------------------------
   int           cm_ph;
   int           cm_n;
   logic [1:0]   cm_kind;
   logic [127:0] cm_buf, cm_key, cm_pt, cm_ct;

   always @(negedge clk) begin
      if (!rst_) begin
         cm_ph      <= 0;
         cm_n       <= 0;
         core_ready <= 1'b1;
         core_ok    <= 1'b0;
         core_dout  <= 8'h00;
      end else begin
         case (cm_ph)
            0: begin
               if (core_cmd == 2'b10 || core_cmd == 2'b11) begin
                  cm_kind    <= core_cmd;
                  core_ready <= 1'b0;
                  cm_n       <= 0;
                  cm_ph      <= 1;
               end else if (core_cmd == 2'b01) begin
                  core_ready <= 1'b0;
                  cm_n       <= 0;
                  cm_ph      <= 3;
               end
            end
            1: begin
               cm_buf[8*cm_n +: 8] <= core_din;
               if (cm_n == 15) begin cm_n <= 0; cm_ph <= 2; end
               else cm_n <= cm_n + 1;
            end
            2: begin
               if (cm_n == 1) begin
                  if (cm_kind == 2'b10) cm_key <= cm_buf;
                  else cm_pt <= cm_buf;
                  core_ready <= 1'b1;
                  cm_ph      <= 0;
               end else cm_n <= cm_n + 1;
            end
            3: begin
               if (!ok_never && cm_n >= ok_lat) begin
                  cm_ct     <= ref_cipher(cm_key, cm_pt);
                  core_ok   <= 1'b1;
                  core_dout <= 8'($urandom);
                  cm_n      <= 0;
                  cm_ph     <= 4;
               end else if (!ok_never) cm_n <= cm_n + 1;
            end
            default: begin
               if (cm_n + 1 >= ok_cycles) begin
                  core_ok    <= 1'b0;
                  core_dout  <= 8'h00;
                  core_ready <= 1'b1;
                  cm_ph      <= 0;
               end else begin
                  core_dout <= cm_ct[8*cm_n +: 8];
                  cm_n      <= cm_n + 1;
               end
            end
         endcase
      end
   end

   // ---------------- command monitor ----------------------------------------
   int         n_cmd   = 0;
   int         n_kcmd  = 0;
   int         cmd_bad = 0;
   logic [1:0] prev_cmd;

   always @(negedge clk) begin
      if (!rst_) begin
         prev_cmd <= 2'b00;
      end else begin
         prev_cmd <= core_cmd;
         if (core_cmd != 2'b00) begin
            n_cmd <= n_cmd + 1;
            if (core_cmd == 2'b10) n_kcmd <= n_kcmd + 1;
            if (!core_ready || core_ok || prev_cmd != 2'b00) cmd_bad <= cmd_bad + 1;
         end
      end
   end

   // ---------------- host-side tasks ---------------------------------------
   task automatic do_reset();
      rst_ = 1'b0;
      repeat (3) @(negedge clk);
      rst_ = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_key(input logic [127:0] k);
      bit ok = 1'b0;
      key_in = k; key_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (key_ready) ok = 1'b1;
         @(negedge clk);
      end
      key_valid = 1'b0;
      chk("key_hs", ok, 1);
   endtask

   task automatic send_pt(input logic [127:0] p);
      bit ok = 1'b0;
      pt_in = p; pt_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (pt_ready) ok = 1'b1;
         @(negedge clk);
      end
      pt_valid = 1'b0;
      chk("pt_hs", ok, 1);
   endtask

   task automatic wait_idle(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         if (!busy) ok = 1'b1;
         else @(negedge clk);
      end
      chk(tag, ok, 1);
   endtask

   task automatic wait_done(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         if (ct_valid || err) ok = 1'b1;
         else @(negedge clk);
      end
      chk(tag, ok, 1);
   endtask

   task automatic load_key(input logic [127:0] k);
      int c0;
      c0 = n_kcmd;
      send_key(k);
      wait_idle("key_idle");
      chk("key_cmd_once", n_kcmd - c0, 1);
      chk("key_bytes", cm_key, k);
      chk("key_rdy_after", key_ready, 0);
      chk("pt_rdy_after", pt_ready, 1);
   endtask

   // Drains one result after holding ct_ready low for 'hold' cycles
   task automatic drain(input int hold, input logic [127:0] exp);
      logic [127:0] snap;
      snap = ct_out;
      chk("ct", ct_out, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("bp_ctv", ct_valid, 1);
         chk("bp_ct", ct_out, snap);
         chk("bp_ptrdy", pt_ready, 0);
      end
      ct_ready = 1'b1;
      @(negedge clk);
      chk("ct_clr", ct_valid, 0);
      @(negedge clk);
      chk("ptrdy_back", pt_ready, 1);
      ct_ready = 1'b0;
   endtask

   // ---------------- main sequence -----------------------------------------
   initial begin
      logic [127:0] k, p;
      bit found;
      bit any_rdy;
      int c0;
      int t;

      rst_ = 1'b0; key_valid = 1'b0; pt_valid = 1'b0; ct_ready = 1'b0;
      key_in = '0; pt_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_flags", {key_ready, pt_ready, ct_valid, busy, err}, 0);
      chk("rst_core", {core_cmd, core_din}, 0);
      chk("rst_ct", ct_out, 0);
      rst_ = 1'b1;
      repeat (2) @(negedge clk);
      chk("key_rdy_idle", key_ready, 1);

      // Plaintext offered before any key must be refused
      c0 = n_cmd; any_rdy = 1'b0;
      pt_in = 128'h1234; pt_valid = 1'b1;
      repeat (8) begin any_rdy |= pt_ready; @(negedge clk); end
      pt_valid = 1'b0;
      chk("nokey_ptrdy", any_rdy, 0);
      chk("nokey_cmd", n_cmd - c0, 0);

      // FIPS-197 vector with a 20-cycle backpressure hold
      load_key(FIPS_KEY);
      send_pt(FIPS_PT);
      wait_done("fips_done");
      chk("fips_err", err, 0);
      drain(20, FIPS_CT);

      // Random plaintexts, random ok latency, random backpressure
      for (int n = 0; n < 6; n++) begin
         p = {$urandom, $urandom, $urandom, $urandom};
         ok_lat = int'($urandom_range(2, 15));
         send_pt(p);
         wait_done("rnd_done");
         drain(int'($urandom_range(0, 4)), ref_cipher(FIPS_KEY, p));
      end

      // Reset while byte 7 of a plaintext is on core_din
      p = {$urandom, $urandom, $urandom, $urandom};
      send_pt(p);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (core_cmd == 2'b11) found = 1'b1;
         else @(negedge clk);
      end
      chk("pcmd_seen", found, 1);
      repeat (8) @(negedge clk);
      chk("din_b7", core_din, p[63:56]);
      #2 rst_ = 1'b0;
      #1;
      chk("arst_flags", {key_ready, pt_ready, ct_valid, busy, err}, 0);
      chk("arst_core", {core_cmd, core_din}, 0);
      chk("arst_ct", ct_out, 0);
      repeat (2) @(negedge clk);
      rst_ = 1'b1;
      repeat (2) @(negedge clk);
      chk("arst_keyrdy", key_ready, 1);

      // ok window collapses mid-capture
      k = {$urandom, $urandom, $urandom, $urandom};
      load_key(k);
      ok_lat = 4; ok_cycles = 9;
      send_pt(128'hABCD);
      wait_done("abort_done");
      chk("abort_err", err, 1);
      chk("abort_ctv", ct_valid, 0);
      chk("abort_busy", busy, 0);
      ok_cycles = 17;
      repeat (12) @(negedge clk);

      // Core never raises ok
      do_reset();
      chk("tmo_err_clr", err, 0);
      load_key(FIPS_KEY);
      ok_never = 1'b1;
      send_pt(128'h5555);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (core_cmd == 2'b01) found = 1'b1;
         else @(negedge clk);
      end
      chk("scmd_seen", found, 1);
      t = 0;
      for (int i = 1; i <= 100 && t == 0; i++) begin
         @(negedge clk);
         if (i == 60) chk("tmo_early", err, 0);
         if (err) t = i;
      end
      chk("tmo_window", (t >= 63 && t <= 66), 1);
      chk("tmo_busy", busy, 0);
      chk("tmo_ctv", ct_valid, 0);
      ok_never = 1'b0;

      chk("cmd_rules", cmd_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
